// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels between two requesters and the ALU arbiter
//   req_valid  requester -> arbiter  per-port request valid, bit n = port n
//   req_ready  arbiter -> requester  per-port request accept, one-hot or zero
//   req_op     requester -> arbiter  per-port ALU opcode
//   req_a      requester -> arbiter  per-port operand A
//   req_b      requester -> arbiter  per-port operand B
//   rsp_valid  arbiter -> requester  per-port result valid, one-hot or zero
//   rsp_ready  requester -> arbiter  per-port result accept
//   rsp_data   arbiter -> requester  shared result, meaningful only with rsp_valid
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][OP_W-1:0]   req_op;
    logic [1:0][DATA_W-1:0] req_a;
    logic [1:0][DATA_W-1:0] req_b;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [DATA_W-1:0]      rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters, one op in flight
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   bus         request/response channels (slave side)
//   alu_op_o    registered opcode to the ALU
//   alu_a_o     registered operand A to the ALU
//   alu_b_o     registered operand B to the ALU
//   alu_data_i  combinational ALU result
//   busy_o      high whenever a transaction is in progress
//   grant_id_o  port owning the current or last transaction
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    alu_arbiter_if.slave      bus,
    output logic [OP_W-1:0]   alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              busy_o,
    output logic              grant_id_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q;
    logic              prio_q;
    logic              grant_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              win_d;

    // A lone requester wins outright; the priority pointer only breaks ties.
    assign win_d = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];

    // Gated by rst_ni so every output reads zero while reset is held,
    // even if a requester keeps valid asserted.
    assign bus.req_ready = (rst_ni && state_q == IDLE && |bus.req_valid) ? {win_d, !win_d} : 2'b00;
    assign bus.rsp_valid = (state_q == RESP) ? {grant_q, !grant_q} : 2'b00;
    assign bus.rsp_data  = res_q;
    assign alu_op_o      = op_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign busy_o        = state_q != IDLE;
    assign grant_id_o    = grant_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (|bus.req_valid) begin
                    op_q    <= bus.req_op[win_d];
                    a_q     <= bus.req_a[win_d];
                    b_q     <= bus.req_b[win_d];
                    grant_q <= win_d;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q   <= alu_data_i;
                    state_q <= RESP;
                end
                RESP: if (bus.rsp_ready[grant_q]) begin
                    prio_q  <= !grant_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] SUB  = 4'h1;
    localparam logic [3:0] SLTU = 4'h3;
    localparam logic [3:0] SRA  = 4'h5;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_data;
    logic        busy;
    logic        grant_id;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];

    alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .alu_op_o  (alu_op),
        .alu_a_o   (alu_a),
        .alu_b_o   (alu_b),
        .alu_data_i(alu_data),
        .busy_o    (busy),
        .grant_id_o(grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_data = 32'h0;
        case (alu_op)
            ADD:     alu_data = alu_a + alu_b;
            SUB:     alu_data = alu_a - alu_b;
            SLTU:    alu_data = {31'h0, alu_a < alu_b};
            SRA:     alu_data = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_data = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a response, then pops and compares the scoreboard head.
    task automatic do_rsp(input string tag, input int budget);
        exp_t e;
        int   n = 0;
        while (bus.rsp_valid === 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.rsp_valid === 2'b00) begin
            chk({tag, "_timeout"}, 32'h0, 32'h1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, {30'h0, bus.rsp_valid}, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"}, {30'h0, bus.rsp_valid}, {30'h0, e.port, !e.port});
            chk({tag, "_rsp_data"}, bus.rsp_data, e.data);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, {30'h0, bus.req_ready}, 32'h0);
        chk({tag, "_rsp_valid"}, {30'h0, bus.rsp_valid}, 32'h0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 32'h0);
        chk({tag, "_alu_op"}, {28'h0, alu_op}, 32'h0);
        chk({tag, "_alu_a"}, alu_a, 32'h0);
        chk({tag, "_alu_b"}, alu_b, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_grant"}, {31'h0, grant_id}, 32'h0);
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("por");
        rst_n = 1'b1;

        // Contention: both ports valid continuously, grants alternate from port 0.
        bus.req_valid = 2'b11;
        bus.req_op[0] = SUB;  bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd7;
        bus.req_op[1] = SLTU; bus.req_a[1] = 32'd1; bus.req_b[1] = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont%0d_ready", k), {30'h0, bus.req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
            push(k % 2 == 1, (k % 2 == 0) ? 32'hFFFF_FFFE : 32'h0000_0001);
            @(negedge clk);
            chk($sformatf("cont%0d_grant", k), {31'h0, grant_id}, k % 2);
            chk($sformatf("cont%0d_exec_ready", k), {30'h0, bus.req_ready}, 32'h0);
            do_rsp($sformatf("cont%0d", k), 4);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);

        // Lone requester on port 1 while the pointer favours port 0.
        bus.req_valid = 2'b10;
        bus.req_op[1] = ADD; bus.req_a[1] = 32'd10; bus.req_b[1] = 32'd20;
        #1;
        chk("lone_ready", {30'h0, bus.req_ready}, 32'h2);
        push(1'b1, 32'd30);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("lone_grant", {31'h0, grant_id}, 32'h1);
        do_rsp("lone", 4);
        @(negedge clk);

        // Single ADD on port 0 with signed overflow.
        bus.req_valid = 2'b01;
        bus.req_op[0] = ADD; bus.req_a[0] = 32'h7FFF_FFFF; bus.req_b[0] = 32'h1;
        #1;
        chk("add_ready", {30'h0, bus.req_ready}, 32'h1);
        chk("add_idle_busy", {31'h0, busy}, 32'h0);
        push(1'b0, 32'h8000_0000);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_a[0] = 32'hDEAD_BEEF;
        chk("add_busy", {31'h0, busy}, 32'h1);
        chk("add_alu_op", {28'h0, alu_op}, {28'h0, ADD});
        chk("add_alu_a", alu_a, 32'h7FFF_FFFF);
        chk("add_alu_b", alu_b, 32'h1);
        chk("add_exec_rsp", {30'h0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        chk("add_resp_alu_a", alu_a, 32'h7FFF_FFFF);
        do_rsp("add", 1);
        @(negedge clk);
        chk("add_done_busy", {31'h0, busy}, 32'h0);

        // Backpressure: port 1 SRA wins the tie, port 0 waits behind it.
        bus.req_valid = 2'b11;
        bus.req_op[1] = SRA; bus.req_a[1] = 32'h8000_0000; bus.req_b[1] = 32'd4;
        bus.req_op[0] = ADD; bus.req_a[0] = 32'd2;         bus.req_b[0] = 32'd3;
        bus.rsp_ready = 2'b01;
        #1;
        chk("bp_ready", {30'h0, bus.req_ready}, 32'h2);
        push(1'b1, 32'hF800_0000);
        @(negedge clk);
        bus.req_valid = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp%0d_rsp_valid", k), {30'h0, bus.rsp_valid}, 32'h2);
            chk($sformatf("bp%0d_rsp_data", k), bus.rsp_data, 32'hF800_0000);
            chk($sformatf("bp%0d_req_ready", k), {30'h0, bus.req_ready}, 32'h0);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b11;
        do_rsp("bp_sra", 1);
        @(negedge clk);
        chk("bp_p0_ready", {30'h0, bus.req_ready}, 32'h1);
        push(1'b0, 32'd5);
        @(negedge clk);
        bus.req_valid = 2'b00;
        do_rsp("bp_p0", 4);
        @(negedge clk);

        // Undefined opcode returns whatever the ALU gives (zero).
        bus.req_valid = 2'b01;
        bus.req_op[0] = 4'hF; bus.req_a[0] = 32'hFFFF_FFFF; bus.req_b[0] = 32'hFFFF_FFFF;
        #1;
        chk("undef_ready", {30'h0, bus.req_ready}, 32'h1);
        push(1'b0, 32'h0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("undef_alu_op", {28'h0, alu_op}, 32'hF);
        do_rsp("undef", 4);
        @(negedge clk);

        // Reset mid-EXEC aborts the transaction; pointer returns to port 0.
        bus.req_valid = 2'b10;
        bus.req_op[1] = ADD; bus.req_a[1] = 32'd1; bus.req_b[1] = 32'd1;
        @(negedge clk);
        chk("rst_exec_busy", {31'h0, busy}, 32'h1);
        bus.req_valid = 2'b11;
        bus.req_op[0] = SUB; bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd4;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_tie_ready", {30'h0, bus.req_ready}, 32'h1);
        push(1'b0, 32'd5);
        @(negedge clk);
        bus.req_valid = 2'b00;
        do_rsp("rst_tie", 4);
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
